// File: rtl/adsr_pkg.sv
// adsr_pkg: shared envelope state encoding and level width
// Exports LVL_W (envelope level width) and state_t (IDLE..RELEASE, 3-bit).
package adsr_pkg;
   localparam int LVL_W = 8;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } state_t;
endpackage

// File: rtl/env_tick_gen.sv
// env_tick_gen: free-running divider, one-cycle tick every TICK_DIV clocks
// Ports: clk, rst (async, active-high), tick (high for one cycle per period).
module env_tick_gen #(
   parameter int TICK_DIV = 12000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= cnt == LAST ? '0 : cnt + 1'b1;
   assign tick = cnt == LAST;
endmodule

// File: rtl/adsr_envelope.sv
// adsr_envelope: ADSR envelope shaper scaling the AC part of a tone sample
// Ports: clk, rst (async, active-high), gate (async key level),
//        sample_in (unsigned tone), sample_out (enveloped, 2-cycle latency),
//        level (current envelope level), active (state is not IDLE).
module adsr_envelope
   import adsr_pkg::*;
#(
   parameter int DATA_W       = 11,
   parameter int MID          = 638,
   parameter int TICK_DIV     = 12000,
   parameter int ATTACK_STEP  = 8,
   parameter int DECAY_STEP   = 2,
   parameter int SUSTAIN_LVL  = 160,
   parameter int RELEASE_STEP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              gate,
   input  logic [DATA_W-1:0] sample_in,
   output logic [DATA_W-1:0] sample_out,
   output logic [LVL_W-1:0]  level,
   output logic              active
);
   localparam int LW = LVL_W + 1;
   localparam logic [LW-1:0] FULL = LW'((1 << LVL_W) - 1);
   localparam logic [LW-1:0] A_S  = LW'(ATTACK_STEP);
   localparam logic [LW-1:0] D_S  = LW'(DECAY_STEP);
   localparam logic [LW-1:0] SUS  = LW'(SUSTAIN_LVL);
   localparam logic [LW-1:0] R_S  = LW'(RELEASE_STEP);
   localparam int PW = DATA_W + 1 + LW;
   localparam int SW = PW + 1;
   localparam logic signed [DATA_W:0] MID_D = (DATA_W + 1)'(MID);
   localparam logic signed [SW-1:0]   MID_S = SW'(MID);
   localparam logic signed [SW-1:0]   MAX_S = SW'((1 << DATA_W) - 1);
   logic tick, rise, fall;
   logic [2:0] gs;
   state_t state, edge_state, nstate;
   logic [LVL_W-1:0] nlevel;
   logic [LW-1:0] lv, up_sat, dn_dec, dn_rel, up;
   logic signed [DATA_W:0] d;
   logic signed [PW-1:0] p_q;
   logic signed [SW-1:0] s;
   env_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
   // gs[1:0] synchronize the pin; gs[2] is the previous synchronized value
   always_ff @(posedge clk or posedge rst)
      if (rst) gs <= '0;
      else gs <= {gs[1:0], gate};
   assign rise = gs[1] & ~gs[2];
   assign fall = ~gs[1] & gs[2];
   assign lv     = {1'b0, level};
   assign up     = lv + A_S;
   assign up_sat = up > FULL ? FULL : up;
   assign dn_dec = lv >= SUS + D_S ? lv - D_S : SUS;
   assign dn_rel = lv >= R_S ? lv - R_S : '0;
   // edge decides the state first; a coincident tick then steps by the new state's rule
   always_comb begin
      edge_state = rise ? ATTACK :
                   (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) ? RELEASE : state;
      nstate = edge_state;
      nlevel = level;
      if (tick && edge_state == ATTACK) begin
         nlevel = up_sat[LVL_W-1:0];
         nstate = up_sat == FULL ? DECAY : ATTACK;
      end else if (tick && edge_state == DECAY) begin
         nlevel = dn_dec[LVL_W-1:0];
         nstate = dn_dec == SUS ? SUSTAIN : DECAY;
      end else if (tick && edge_state == RELEASE) begin
         nlevel = dn_rel[LVL_W-1:0];
         nstate = dn_rel == '0 ? IDLE : RELEASE;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         level <= '0;
      end else begin
         state <= nstate;
         level <= nlevel;
      end
   assign active = state != IDLE;
   assign d = $signed({1'b0, sample_in}) - MID_D;
   // floor shift of the signed product keeps the DC point exact at any level
   assign s = SW'(p_q >>> LVL_W) + MID_S;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         p_q        <= '0;
         sample_out <= DATA_W'(MID);
      end else begin
         p_q        <= PW'(d) * PW'($signed({1'b0, level}));
         sample_out <= s < 0 ? '0 : s > MAX_S ? '1 : s[DATA_W-1:0];
      end
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: self-checking bench for adsr_envelope with TICK_DIV=4
module tb_adsr_envelope;
   localparam int TDIV = 4;
   localparam int MIDV = 638;
   typedef struct { int in; int exp; } vec_t;
   logic clk = 0, rst = 1, gate = 0;
   logic [10:0] sample_in = 11'd1000;
   logic [10:0] sample_out;
   logic [7:0]  level;
   logic        active;
   int n_chk = 0, n_fail = 0;
   bit chk_en = 0;
   int m_state = 0, m_level = 0, ecnt = 0, stage = MIDV, exp_out = MIDV;
   bit g1m = 0, g2m = 0, g3m = 0;
   adsr_envelope #(.TICK_DIV(TDIV)) dut (
      .clk(clk), .rst(rst), .gate(gate), .sample_in(sample_in),
      .sample_out(sample_out), .level(level), .active(active)
   );
   always #5 clk = ~clk;
   function automatic int scale(input int smp, input int l);
      int p, q;
      p = (smp - MIDV) * l;
      q = p / 256;
      if (p < 0 && p % 256 != 0) q = q - 1;
      q = q + MIDV;
      return q < 0 ? 0 : q > 2047 ? 2047 : q;
   endfunction
   // reference: gate seen after 3 edges, tick every TDIV edges, level rules as plain min/max arithmetic
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_state <= 0; m_level <= 0; ecnt <= 0; stage <= MIDV; exp_out <= MIDV;
         g1m <= 0; g2m <= 0; g3m <= 0;
      end else begin
         automatic int st = m_state;
         automatic int lv = m_level;
         if (g2m && !g3m) st = 1;
         else if (!g2m && g3m && st >= 1 && st <= 3) st = 4;
         if (ecnt % TDIV == TDIV - 1) begin
            if (st == 1) begin lv = lv + 8 > 255 ? 255 : lv + 8; if (lv == 255) st = 2; end
            else if (st == 2) begin lv = lv - 2 < 160 ? 160 : lv - 2; if (lv == 160) st = 3; end
            else if (st == 4) begin lv = lv - 4 < 0 ? 0 : lv - 4; if (lv == 0) st = 0; end
         end
         exp_out <= stage;
         stage <= scale(int'(sample_in), m_level);
         m_state <= st; m_level <= lv; ecnt <= ecnt + 1;
         g1m <= gate; g2m <= g1m; g3m <= g2m;
      end
   end
   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask
   always @(negedge clk)
      if (chk_en) begin
         check("model_level", int'(level), m_level);
         check("model_active", int'(active), int'(m_state != 0));
         check("model_sample_out", int'(sample_out), exp_out);
      end
   task automatic wait_level(input string name, input int target, input int limit,
                             input int start, output int steps, output int peak);
      int prev;
      prev = start; steps = 0; peak = start;
      if (int'(level) != prev) begin steps++; prev = int'(level); end
      for (int i = 0; i < limit && int'(level) != target; i++) begin
         @(negedge clk);
         if (int'(level) != prev) steps++;
         prev = int'(level);
         if (prev > peak) peak = prev;
      end
      check(name, int'(level), target);
   endtask
   initial begin
      vec_t vecs[3];
      int st, pk;
      vecs[0] = '{1278, 1275};
      vecs[1] = '{0, 2};
      vecs[2] = '{638, 638};
      repeat (3) @(negedge clk);
      chk_en = 1;
      check("rst_sample_out", int'(sample_out), 638);
      check("rst_level", int'(level), 0);
      check("rst_active", int'(active), 0);
      rst = 0;
      repeat (6) @(negedge clk);
      check("idle_sample_out", int'(sample_out), 638);
      check("idle_active", int'(active), 0);
      gate = 1;
      wait_level("attack_peak", 255, 300, 0, st, pk);
      check("attack_steps", st, 32);
      for (int k = 0; k < 5; k++) begin
         if (k < 3) sample_in = 11'(vecs[k].in);
         if (k >= 2) check("scale_255", int'(sample_out), vecs[k - 2].exp);
         if (k < 4) @(negedge clk);
      end
      sample_in = 11'd1000;
      wait_level("decay_floor", 160, 400, 255, st, pk);
      check("decay_steps", st, 48);
      repeat (20) @(negedge clk);
      check("sustain_hold", int'(level), 160);
      check("sustain_active", int'(active), 1);
      gate = 0;
      wait_level("release_zero", 0, 400, 160, st, pk);
      check("release_steps", st, 40);
      @(negedge clk);
      check("release_idle", int'(active), 0);
      gate = 1;
      wait_level("midattack_64", 64, 200, 0, st, pk);
      gate = 0;
      wait_level("midattack_rel_zero", 0, 200, 64, st, pk);
      check("midattack_rel_steps", st, 16);
      check("midattack_rel_peak", pk, 64);
      gate = 1;
      wait_level("retrig_sustain", 160, 600, 0, st, pk);
      gate = 0;
      wait_level("retrig_at_100", 100, 200, 160, st, pk);
      check("retrig_rel_steps", st, 15);
      gate = 1;
      wait_level("retrig_peak", 255, 200, 100, st, pk);
      check("retrig_attack_steps", st, 20);
      wait_level("pre_reset_sustain", 160, 400, 255, st, pk);
      @(posedge clk);
      #3 rst = 1;
      #1;
      check("async_rst_sample_out", int'(sample_out), 638);
      check("async_rst_level", int'(level), 0);
      check("async_rst_active", int'(active), 0);
      gate = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      repeat (4) @(negedge clk);
      check("post_rst_idle", int'(active), 0);
      gate = 1;
      wait_level("post_rst_attack", 255, 300, 0, st, pk);
      check("post_rst_attack_steps", st, 32);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         sample_in = 11'($urandom_range(0, 2047));
         if ($urandom_range(0, 79) == 0) gate = ~gate;
      end
      @(negedge clk);
      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Envelope shaper between the harmonic generator and the delta-sigma DAC stage. It takes the 11-bit unsigned tone sample and a key gate, runs an attack/decay/sustain/release (ADSR) state machine on a slow envelope tick, and scales the AC part of the sample by the current 8-bit level around a fixed DC midpoint. The output sample feeds the DAC modulator unchanged in width.

## Interface
- DATA_W, 11, sample width in and out (unsigned offset binary)
- MID, 638, DC midpoint of the incoming sample; also the silent output value
- TICK_DIV, 12000, clk cycles per envelope tick (1 kHz at 12 MHz)
- ATTACK_STEP, 8, level increment per tick in ATTACK
- DECAY_STEP, 2, level decrement per tick in DECAY
- SUSTAIN_LVL, 160, sustain level (0..255)
- RELEASE_STEP, 4, level decrement per tick in RELEASE

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- gate  in  1  key held (level, asynchronous to clk)
- sample_in  in  DATA_W  tone sample
- sample_out  out  DATA_W  enveloped sample, registered
- level  out  8  current envelope level
- active  out  1  high whenever state is not IDLE

## Operation
- gate passes through a 2-flop synchronizer, then a third flop for edge detection.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Gate edges are evaluated every clk. Level updates occur only on a tick.
- Rising gate edge in any state: go to ATTACK with the level unchanged, so retrigger does not click.
- Falling gate edge in ATTACK, DECAY or SUSTAIN: go to RELEASE.
- ATTACK tick: level = min(level+ATTACK_STEP, 255). When the result is 255, go to DECAY on the same tick.
- DECAY tick: level = max(level−DECAY_STEP, SUSTAIN_LVL). When the result equals SUSTAIN_LVL, go to SUSTAIN.
- SUSTAIN: the level holds.
- RELEASE tick: level = max(level−RELEASE_STEP, 0). When the result is 0, go to IDLE.
- Edge and tick in the same cycle: the state transition takes priority, and the tick step is applied using the new state's rule.
- Arithmetic:
  - d = signed(sample_in) − MID, DATA_W+1 bits.
  - p = d × level, signed.
  - sample_out = MID + (p >>> 8), using an arithmetic shift (floor).
  - The result is clamped to [0, 2^DATA_W−1].
- When level is 0, sample_out is MID.

## Timing
- Reset values:
  - state IDLE, level 0, active 0
  - sample_out MID
  - tick counter 0, synchronizer flops 0
- The tick counter is free-running from reset and counts 0..TICK_DIV−1. It is not restarted by gate, so the first step occurs 1..TICK_DIV cycles after entry.
- Gate latency: a gate change at the pin is seen as an edge 3 clk later. state and active update on the following edge.
- Sample path: 2-stage pipeline.
  - Stage 1 registers d × level.
  - Stage 2 registers the shift, add and clamp.
  - sample_out reflects the sample_in and level values present 2 cycles earlier.
- Asserting rst mid-note forces the reset values immediately. After release the block restarts in IDLE.
- Nominal envelope durations from zero with defaults:
  - attack: 32 ticks
  - decay: 48 ticks (255→160)
  - release from sustain: 40 ticks

## Structure
- Shared package `adsr_pkg`: state enum (3-bit encoding IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4) and level width constant 8.
- Sub-module `env_tick_gen`: parameterised divider producing a 1-cycle tick every TICK_DIV clocks.
- The top holds the synchronizer, FSM and level register, and the 2-stage scaler.

## Test plan
Benches use TICK_DIV=4.
- Reset check: assert rst with sample_in=1000 → sample_out=638, level=0, active=0. These hold until the first rising gate.
- Full envelope: gate 1 held → level reaches 255 after 32 ticks, then 160 after a further 48 ticks, and stays in SUSTAIN. Gate 0 → level reaches 0 after 40 ticks, then IDLE with active=0.
- Scaling extremes at level 255:
  - sample_in=1278 → sample_out=1275.
  - sample_in=0 → sample_out=2.
  - sample_in=638 → sample_out=638.
  - Each appears 2 cycles after the input.
- Release at mid-attack: release gate at level 64 → RELEASE, level falls 64→0 in 16 ticks. DECAY is never entered.
- Retrigger at mid-release: re-press gate at level 100 → ATTACK from 100, reaching 255 in 20 ticks.
- Asynchronous reset mid-SUSTAIN: assert rst asynchronously between clk edges → sample_out=638 and level=0 before the next clk edge. Normal operation resumes after deassertion.
